// File: rtl/sim_run_monitor.sv
// Run-control monitor for SoC benches: generates the core reset, counts RUN cycles
// and retirements, detects tohost/halt/timeout end-of-test and keeps a PC trace ring.
module sim_run_monitor #(
    parameter int                XLEN           = 32,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 50,
    parameter int                HALT_REPEAT    = 8,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = 32'h8000_1000,
    parameter int                TRACE_DEPTH    = 16,
    localparam int               IDX_W          = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst_n,
    input  logic              retire_valid,
    input  logic [XLEN-1:0]   retire_pc,
    input  logic              store_valid,
    input  logic [XLEN-1:0]   store_addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              done,
    output logic              pass,
    output logic [XLEN-2:0]   fail_code,
    output logic              timeout,
    output logic              halted,
    output logic [31:0]       cycle_count,
    output logic [31:0]       retired_count,
    input  logic [IDX_W-1:0]  trace_rd_idx,
    output logic [XLEN-1:0]   trace_rd_pc,
    output logic [IDX_W:0]    trace_count
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       hold_cnt;
    logic [31:0]       halt_cnt;
    logic [31:0]       halt_nxt;
    logic [31:0]       cycle_inc;
    logic [XLEN-1:0]   last_pc;
    logic              have_last;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  rd_slot;
    logic              tohost_hit;
    logic              halt_hit;
    logic              timeout_hit;
    logic [XLEN-1:0]   trace_mem [TRACE_DEPTH];

    always_comb begin
        state_nxt   = state;
        cycle_inc   = cycle_count + 32'd1;
        // The first retire after HOLD has no predecessor, so it always starts a fresh run of 1.
        halt_nxt    = (have_last && retire_pc == last_pc) ? halt_cnt + 32'd1 : 32'd1;
        tohost_hit  = store_valid && store_addr == TOHOST_ADDR && store_data[0];
        halt_hit    = retire_valid && halt_nxt == 32'(HALT_REPEAT);
        timeout_hit = cycle_inc == 32'(TIMEOUT_CYCLES);
        case (state)
            S_HOLD: begin
                if (hold_cnt == 32'(RESET_CYCLES - 1)) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (tohost_hit)
                    state_nxt = (store_data == {{(XLEN-1){1'b0}}, 1'b1}) ? S_PASS : S_FAIL;
                else if (halt_hit)
                    state_nxt = S_HALT;
                else if (timeout_hit)
                    state_nxt = S_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_HOLD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_n    <= 1'b0;
            hold_cnt      <= '0;
            halt_cnt      <= '0;
            last_pc       <= '0;
            have_last     <= 1'b0;
            head          <= '0;
            trace_count   <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            fail_code     <= '0;
        end else begin
            if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + 32'd1;
                if (state_nxt == S_RUN) core_rst_n <= 1'b1;
            end
            if (state == S_RUN) begin
                cycle_count <= cycle_inc;
                if (retire_valid) begin
                    retired_count <= retired_count + 32'd1;
                    head          <= head + IDX_W'(1);
                    halt_cnt      <= halt_nxt;
                    last_pc       <= retire_pc;
                    have_last     <= 1'b1;
                    if (trace_count != (IDX_W+1)'(TRACE_DEPTH))
                        trace_count <= trace_count + (IDX_W+1)'(1);
                end
                if (state_nxt == S_FAIL) fail_code <= store_data[XLEN-1:1];
            end
        end
    end

    // Trace RAM carries no reset; trace_count alone decides which entries are readable.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RUN && retire_valid) trace_mem[head] <= retire_pc;
    end

    assign rd_slot     = head - IDX_W'(1) - trace_rd_idx;
    assign trace_rd_pc = ({1'b0, trace_rd_idx} < trace_count) ? trace_mem[rd_slot] : '0;

    assign pass    = (state == S_PASS);
    assign timeout = (state == S_TIMEOUT);
    assign halted  = (state == S_HALT);
    assign done    = (state == S_PASS) || (state == S_FAIL) ||
                     (state == S_TIMEOUT) || (state == S_HALT);

endmodule

// File: tb/tb_sim_run_monitor.sv
// Bench for sim_run_monitor: vector table for tohost decoding, directed corner
// sequences, and randomized runs against a history-based reference model.
module tb_sim_run_monitor;

    localparam int          XLEN   = 32;
    localparam int          RC     = 4;
    localparam int          TO     = 50;
    localparam int          HR     = 8;
    localparam int          TD     = 16;
    localparam int          IDX_W  = 4;
    localparam logic [31:0] TOHOST = 32'h8000_1000;

    // clock / reset block
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core_rst_n;
    logic             retire_valid = 1'b0;
    logic [31:0]      retire_pc = '0;
    logic             store_valid = 1'b0;
    logic [31:0]      store_addr = '0;
    logic [31:0]      store_data = '0;
    logic             done, pass, timeout, halted;
    logic [30:0]      fail_code;
    logic [31:0]      cycle_count, retired_count;
    logic [IDX_W-1:0] trace_rd_idx = '0;
    logic [31:0]      trace_rd_pc;
    logic [IDX_W:0]   trace_count;

    always #5 clk = ~clk;

    sim_run_monitor #(
        .XLEN(XLEN), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .HALT_REPEAT(HR),
        .TOHOST_ADDR(TOHOST), .TRACE_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst), .core_rst_n(core_rst_n),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout),
        .halted(halted), .cycle_count(cycle_count), .retired_count(retired_count),
        .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_count(trace_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire_valid = 1'b0; retire_pc = '0;
        store_valid = 1'b0; store_addr = '0; store_data = '0;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic sv,
                         input logic [31:0] sa, input logic [31:0] sd);
        retire_valid = rv; retire_pc = pc;
        store_valid = sv; store_addr = sa; store_data = sd;
        cyc();
        idle();
    endtask

    task automatic go_run();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (RC) cyc();
        chk("core_rst_n_up", core_rst_n, 1);
    endtask

    task automatic chk_trace(input string name, input int idx, input logic [31:0] exp);
        trace_rd_idx = IDX_W'(idx);
        #1;
        chk(name, trace_rd_pc, exp);
    endtask

    // reference model: everything derived from the list of PCs retired since reset
    logic [31:0] m_hist[$];
    int          m_hold;
    bit          m_run, m_done, m_pass, m_to, m_halt;
    logic [30:0] m_fc;
    logic [31:0] m_cyc, m_ret;

    function automatic void m_reset();
        m_hist.delete();
        m_hold = 0; m_run = 0; m_done = 0; m_pass = 0; m_to = 0; m_halt = 0;
        m_fc = '0; m_cyc = '0; m_ret = '0;
    endfunction

    function automatic void m_step(input bit rv, input logic [31:0] pc, input bit sv,
                                   input logic [31:0] sa, input logic [31:0] sd);
        bit halt_now;
        if (!m_run) begin
            m_hold++;
            if (m_hold == RC) m_run = 1;
            return;
        end
        if (m_done) return;
        m_cyc++;
        halt_now = 0;
        if (rv) begin
            m_ret++;
            m_hist.push_back(pc);
            if (m_hist.size() >= HR) begin
                halt_now = 1;
                for (int k = 1; k < HR; k++)
                    if (m_hist[m_hist.size()-1-k] != pc) halt_now = 0;
            end
        end
        if (sv && sa == TOHOST && sd[0]) begin
            m_done = 1;
            if (sd == 32'd1) m_pass = 1;
            else m_fc = sd[31:1];
        end else if (halt_now) begin
            m_done = 1; m_halt = 1;
        end else if (m_cyc == TO) begin
            m_done = 1; m_to = 1;
        end
    endfunction

    function automatic logic [31:0] m_trace(input int idx);
        int n;
        n = (m_hist.size() < TD) ? m_hist.size() : TD;
        return (idx < n) ? m_hist[m_hist.size()-1-idx] : 32'd0;
    endfunction

    task automatic check_model();
        int idx;
        chk("rnd_core_rst_n", core_rst_n, m_run);
        chk("rnd_done", done, m_done);
        chk("rnd_pass", pass, m_pass);
        chk("rnd_timeout", timeout, m_to);
        chk("rnd_halted", halted, m_halt);
        chk("rnd_fail_code", fail_code, m_fc);
        chk("rnd_cycle_count", cycle_count, m_cyc);
        chk("rnd_retired_count", retired_count, m_ret);
        chk("rnd_trace_count", trace_count, (m_hist.size() < TD) ? m_hist.size() : TD);
        idx = $urandom_range(0, TD-1);
        chk_trace("rnd_trace_pc", idx, m_trace(idx));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_done;
        bit          exp_pass;
        logic [30:0] exp_fc;
    } store_vec_t;

    store_vec_t vecs[7];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] r_last;
        int          store_pct;

        vecs[0] = '{TOHOST,          32'h0000_0001, 1, 1, 31'd0};
        vecs[1] = '{TOHOST,          32'h0000_0007, 1, 0, 31'd3};
        vecs[2] = '{TOHOST,          32'h0000_0006, 0, 0, 31'd0};
        vecs[3] = '{TOHOST + 32'd4,  32'h0000_0001, 0, 0, 31'd0};
        vecs[4] = '{TOHOST,          32'h0000_0000, 0, 0, 31'd0};
        vecs[5] = '{TOHOST,          32'hFFFF_FFFF, 1, 0, 31'h7FFF_FFFF};
        vecs[6] = '{TOHOST,          32'h0000_0003, 1, 0, 31'd1};

        // reset sequence
        idle();
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_retired_count", retired_count, 0);
        chk("rst_trace_count", trace_count, 0);
        chk("rst_fail_code", fail_code, 0);
        rst = 1'b0;
        for (int e = 1; e <= RC; e++) begin
            retire_valid = 1'b1; retire_pc = 32'h1234;
            cyc();
            chk($sformatf("hold_core_rst_n_e%0d", e), core_rst_n, (e == RC) ? 1 : 0);
            chk($sformatf("hold_cycle_count_e%0d", e), cycle_count, 0);
        end
        idle();
        chk("hold_retired_ignored", retired_count, 0);

        // tohost decode table
        foreach (vecs[i]) begin
            go_run();
            drive(0, '0, 1, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("vec%0d_pass", i), pass, vecs[i].exp_pass);
            chk($sformatf("vec%0d_fail_code", i), fail_code, vecs[i].exp_fc);
        end

        // pass after 5 retires, then frozen
        go_run();
        for (int i = 0; i < 5; i++) drive(1, 32'h8000_0000 + 32'(4*i), 0, '0, '0);
        drive(0, '0, 1, TOHOST, 32'd1);
        chk("pass_done", done, 1);
        chk("pass_pass", pass, 1);
        chk("pass_retired", retired_count, 5);
        chk("pass_cycles", cycle_count, 6);
        for (int i = 0; i < 5; i++)
            drive(1, $urandom, 1, TOHOST, 32'd7);
        chk("frozen_pass", pass, 1);
        chk("frozen_fail_code", fail_code, 0);
        chk("frozen_retired", retired_count, 5);
        chk("frozen_cycles", cycle_count, 6);
        chk("frozen_trace_count", trace_count, 5);
        chk("frozen_core_rst_n", core_rst_n, 1);

        // fail with an ignored even store first
        go_run();
        drive(0, '0, 1, TOHOST, 32'd6);
        chk("fail_even_ignored", done, 0);
        drive(0, '0, 1, TOHOST, 32'd7);
        chk("fail_done", done, 1);
        chk("fail_pass", pass, 0);
        chk("fail_code_3", fail_code, 3);

        // halt on eighth identical retire
        go_run();
        for (int i = 0; i < HR-1; i++) drive(1, 32'h8000_0010, 0, '0, '0);
        chk("halt_not_yet", halted, 0);
        drive(1, 32'h8000_0010, 0, '0, '0);
        chk("halt_halted", halted, 1);
        chk("halt_done", done, 1);
        chk("halt_retired", retired_count, 8);

        // different pc at repeat 7 restarts the run
        go_run();
        for (int i = 0; i < 6; i++) drive(1, 32'h8000_0010, 0, '0, '0);
        drive(1, 32'h8000_0014, 0, '0, '0);
        for (int i = 0; i < 6; i++) drive(1, 32'h8000_0010, 0, '0, '0);
        chk("halt_broken", halted, 0);
        chk("halt_broken_done", done, 0);

        // timeout
        go_run();
        repeat (TO-1) cyc();
        chk("to_not_yet", done, 0);
        chk("to_cycles_49", cycle_count, TO-1);
        cyc();
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);
        chk("to_cycles_50", cycle_count, TO);
        repeat (3) cyc();
        chk("to_cycles_frozen", cycle_count, TO);
        rst = 1'b1;
        cyc();
        chk("mid_rst_done", done, 0);
        chk("mid_rst_core_rst_n", core_rst_n, 0);
        chk("mid_rst_cycles", cycle_count, 0);

        // pass store beats timeout on cycle 50
        go_run();
        repeat (TO-1) cyc();
        drive(0, '0, 1, TOHOST, 32'd1);
        chk("prio_pass", pass, 1);
        chk("prio_pass_no_to", timeout, 0);

        // halt beats timeout on cycle 50
        go_run();
        repeat (TO-HR) cyc();
        for (int i = 0; i < HR; i++) drive(1, 32'h8000_0020, 0, '0, '0);
        chk("prio_halt", halted, 1);
        chk("prio_halt_no_to", timeout, 0);
        chk("prio_halt_cycles", cycle_count, TO);

        // trace wrap
        go_run();
        for (int i = 0; i < 20; i++) drive(1, 32'h100 + 32'(4*i), 0, '0, '0);
        chk("wrap_trace_count", trace_count, 16);
        chk_trace("wrap_idx0", 0, 32'h14C);
        chk_trace("wrap_idx15", 15, 32'h110);
        chk_trace("wrap_idx7", 7, 32'h130);
        go_run();
        for (int i = 0; i < 3; i++) drive(1, 32'h100 + 32'(4*i), 0, '0, '0);
        chk("short_trace_count", trace_count, 3);
        chk_trace("short_idx0", 0, 32'h108);
        chk_trace("short_idx2", 2, 32'h100);
        chk_trace("short_idx3", 3, 32'h0);

        // randomized runs against the model
        r_last = 32'h8000_0000;
        for (int run = 0; run < 9; run++) begin
            store_pct = (run % 3 == 0) ? 0 : ((run % 3 == 1) ? 2 : 10);
            for (int c = 0; c < 72; c++) begin
                bit          rv, sv;
                logic [31:0] pc, sa, sd;
                rv = ($urandom_range(0, 99) < 65);
                if ($urandom_range(0, 99) < 80) pc = r_last;
                else pc = 32'h8000_0000 + 32'(4 * $urandom_range(0, 3));
                if (rv) r_last = pc;
                sv = ($urandom_range(0, 99) < store_pct);
                sa = $urandom_range(0, 1) ? TOHOST : $urandom;
                case ($urandom_range(0, 3))
                    0:       sd = 32'd1;
                    1:       sd = $urandom | 32'd1;
                    2:       sd = $urandom & ~32'd1;
                    default: sd = 32'(2 * $urandom_range(1, 20) + 1);
                endcase
                rst = (c == 0);
                retire_valid = rv; retire_pc = pc;
                store_valid = sv; store_addr = sa; store_data = sd;
                cyc();
                if (c == 0) m_reset();
                else m_step(rv, pc, sv, sa, sd);
                check_model();
            end
            rst = 1'b0;
            idle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_run_monitor.md
Name: sim_run_monitor

Overview:
- Synthesizable run-control and observation block for SoC simulation benches.
- Generates the core reset sequence and counts cycles and retirements.
- Detects end-of-test from a tohost store, a self-loop halt, or a timeout, and keeps a trace ring of the last retired PCs.
- Successor to ad-hoc bench timeout/print logic: parametrised in width, timeout, reset length and trace depth, and adds pass/fail decoding and halt detection.

Parameters:
- XLEN, 32, data/address width.
- RESET_CYCLES, 4, cycles core_rst_n is held low after rst deasserts (>=1).
- TIMEOUT_CYCLES, 50, RUN-state cycles before timeout (>=1).
- HALT_REPEAT, 8, consecutive same-PC retirements that declare halt (>=2).
- TOHOST_ADDR, 32'h8000_1000, store address that ends the test.
- TRACE_DEPTH, 16, trace ring entries (power of 2, >=2).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- core_rst_n, out, 1, generated active-low reset to the SoC.
- retire_valid, in, 1, one instruction retired this cycle.
- retire_pc, in, XLEN, PC of the retired instruction.
- store_valid, in, 1, store issued this cycle.
- store_addr, in, XLEN, store address.
- store_data, in, XLEN, store data.
- done, out, 1, terminal state reached.
- pass, out, 1, tohost reported success.
- fail_code, out, XLEN-1, store_data[XLEN-1:1] of a failing tohost write.
- timeout, out, 1, timeout terminal state.
- halted, out, 1, self-loop terminal state.
- cycle_count, out, 32, RUN-state cycles elapsed.
- retired_count, out, 32, instructions retired.
- trace_rd_idx, in, $clog2(TRACE_DEPTH), 0 = most recent retirement.
- trace_rd_pc, out, XLEN, combinational trace read.
- trace_count, out, $clog2(TRACE_DEPTH)+1, valid trace entries.

Behaviour:
- States: HOLD, RUN, PASS, FAIL, TIMEOUT, HALT.
- Reset: rst=1 at a posedge forces state HOLD, core_rst_n=0, all counters, flags, fail_code and trace_count to 0. Trace RAM contents are don't-care.
- Reset mid-run from any state behaves identically, including terminal states.

HOLD:
- Hold counter increments each cycle.
- After RESET_CYCLES cycles with rst=0, move to RUN and set core_rst_n=1 at that same edge. Example: rst low at edge 0 gives core_rst_n high after edge RESET_CYCLES.
- retire/store inputs are ignored.

RUN, per cycle:
- cycle_count += 1.
- If retire_valid:
  - retired_count += 1.
  - Write retire_pc to the trace head and advance the head.
  - trace_count saturates at TRACE_DEPTH.
- Halt counter:
  - Retire with pc == last retired pc: counter += 1.
  - Retire with a different pc: counter = 1.
  - The first retire after HOLD sets counter = 1.
- Exit checks, in priority order (exactly one fires):
  1. tohost: store_valid and store_addr == TOHOST_ADDR and store_data[0] == 1.
     - store_data == 1: go to PASS, pass=1.
     - Otherwise: go to FAIL, fail_code = store_data[XLEN-1:1].
     - Tohost stores with data[0] == 0 are ignored.
  2. halt: the counter reaches HALT_REPEAT this cycle; go to HALT, halted=1.
  3. timeout: cycle_count reaches TIMEOUT_CYCLES (post-increment value); go to TIMEOUT, timeout=1.
- A retire occurring in the exit cycle is still counted and traced.
- Terminal states:
  - Sticky until rst; done=1.
  - Counters and trace frozen; inputs ignored.
  - core_rst_n stays 1.
- Trace read: trace_rd_pc = entry written trace_rd_idx retirements ago. Returns 0 when trace_rd_idx >= trace_count. Oldest entries are overwritten on wrap.
- Counters are 32-bit and wrap modulo 2^32. Unreachable when TIMEOUT_CYCLES < 2^32.

Test Plan:
- Reset sequence: rst high 2 cycles then low, RESET_CYCLES=4 -> core_rst_n=0 for edges 1-3, 1 after edge 4; cycle_count=0 until RUN.
- Pass: 5 retires, then store 0x8000_1000 <= 1 -> next cycle done=1, pass=1, retired_count=5, later stimulus leaves all outputs unchanged.
- Fail: store 0x8000_1000 <= 0x0000_0007 -> FAIL, fail_code=3, pass=0. A prior store of 0x0000_0006 is ignored.
- Halt: retire pc 0x8000_0010 eight consecutive times with HALT_REPEAT=8 -> halted=1 on the 8th. A different pc at repeat 7 resets the count, so no halt.
- Timeout and priority: no stores, TIMEOUT_CYCLES=50 -> timeout=1 after 50 RUN cycles. A tohost pass store on cycle 50 gives pass=1 instead. Halt and timeout in the same cycle gives halted=1.
- Trace wrap: 20 retires with pc=0x100+4*i, TRACE_DEPTH=16 -> trace_count=16, idx0=0x14C, idx15=0x110. After reset and 3 retires, idx3 reads 0.
